multi_timer: RTL
================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter WIDTH, default 5, bit width of each channel's count and load value (legal range 2..32).
REQ-002 Parameter CHANNELS, default 4, number of independent countdown channels (legal range 1..16).
REQ-003 Derived constant CH_W SHALL equal max(1, clog2(CHANNELS)); it is not overridable.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  CHANNELS  per-channel count enable; bit i gates channel i.
REQ-007 wr_valid  input  1  load strobe, sampled each rising edge.
REQ-008 wr_ch  input  CH_W  target channel index for the load.
REQ-009 wr_value  input  WIDTH  start/reload value for the load.
REQ-010 wr_mode  input  1  mode for the load: 0 = one-shot, 1 = periodic.
REQ-011 count  output  CHANNELS*WIDTH  registered current counts; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-012 busy  output  CHANNELS  bit i high while channel i is in RUN.
REQ-013 trigger  output  CHANNELS  registered single-cycle expiry pulse per channel.

Function
REQ-014 Each channel SHALL hold count, reload (WIDTH bits), mode (1 bit) and a two-state FSM: IDLE, RUN.
REQ-015 A load SHALL occur for channel i when wr_valid=1 and wr_ch=i; wr_ch>=CHANNELS SHALL be ignored with no state change.
REQ-016 On a load: count<=wr_value, reload<=wr_value, mode<=wr_mode, state<=RUN if wr_value!=0, otherwise IDLE.
REQ-017 In RUN with enable[i]=0: count and state SHALL hold.
REQ-018 In RUN with enable[i]=1 and count>1: count SHALL decrement by 1.
REQ-019 Expiry: in RUN with enable[i]=1 and count==1.
REQ-020 On expiry in one-shot mode: count<=0, state<=IDLE.
REQ-021 On expiry in periodic mode: count<=reload, state stays RUN; period = reload enabled cycles.
REQ-022 trigger[i] SHALL be high for exactly the one cycle after the expiry edge; latency from the edge where count==1 is sampled = 1 cycle.
REQ-023 In IDLE, count SHALL hold regardless of enable; no trigger SHALL be generated.
REQ-024 A load coinciding with expiry on the same channel SHALL take priority; no trigger SHALL be generated for that expiry.
REQ-025 A load to one channel SHALL NOT affect any other channel; any number of channels may expire in the same cycle.
REQ-026 Arithmetic is unsigned modulo 2^WIDTH; count never wraps below 0 because the decrement from 1 is replaced by expiry.

Reset
REQ-027 While reset=1 at a rising edge: all counts, reload and mode registers, busy, and trigger SHALL become 0; all states SHALL become IDLE.
REQ-028 Reset SHALL take priority over a simultaneous load and expiry; a pending trigger SHALL be suppressed.
REQ-029 Reset asserted mid-count SHALL abort the channel; counting SHALL resume only after a new load.

Configuration
REQ-030 Macro MULTI_TIMER_IRQ_EN, when defined, SHALL add ports irq_ack (input, CHANNELS), irq_pending (output, CHANNELS) and irq (output, 1).
REQ-031 With the macro defined, irq_pending[i] SHALL set on the edge trigger[i] rises and clear on irq_ack[i]=1; set wins over a simultaneous ack. irq SHALL equal the OR of irq_pending. Reset SHALL clear irq_pending.
REQ-032 With the macro undefined, these ports and their registers SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, then load ch0 value 3 one-shot, enable[0]=1 -> count0 reads 3,2,1,0; trigger[0] high for one cycle while count0==0; busy[0] low from then on.
REQ-034 Load ch1 value 4 periodic, enable held -> trigger[1] pulses every 4 cycles; count1 sequence 4,3,2,1,4,...
REQ-035 Load ch2 value 5, toggle enable[2] 1,0,0,1,... -> count2 holds during low cycles; expiry is delayed by exactly the number of disabled cycles.
REQ-036 Load ch0 value 7 in the cycle where ch0 count==1 with enable=1 -> no trigger; count0=7, busy[0]=1.
REQ-037 Load value 0 -> channel IDLE, count 0, no trigger; wr_ch=CHANNELS -> no channel changes.
REQ-038 Assert reset with ch3 at count 2 in RUN -> next cycle count3=0, busy[3]=0, trigger[3] never pulses; with MULTI_TIMER_IRQ_EN, irq_pending is cleared and an ack coinciding with a trigger leaves irq_pending set.

Source files
------------

// File: rtl/multi_timer.sv
// multi_timer: bank of independent countdown channels.
// Each channel is loaded with a start/reload value and a mode (one-shot or
// periodic), counts down on cycles where its enable bit is high, and emits
// a registered single-cycle trigger pulse on expiry.
// Optional feature: define MULTI_TIMER_IRQ_EN to add sticky per-channel
// interrupt pending flags (irq_pending), an acknowledge input (irq_ack) and
// a combined interrupt output (irq).
module multi_timer #(
    parameter int unsigned  WIDTH    = 5,
    parameter int unsigned  CHANNELS = 4,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic                      wr_valid,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [WIDTH-1:0]          wr_value,
    input  logic                      wr_mode,
`ifdef MULTI_TIMER_IRQ_EN
    input  logic [CHANNELS-1:0]       irq_ack,
    output logic [CHANNELS-1:0]       irq_pending,
    output logic                      irq,
`endif
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       trigger
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Per-channel architectural state
    state_t           r_state   [CHANNELS];
    logic [WIDTH-1:0] r_count   [CHANNELS];
    logic [WIDTH-1:0] r_reload  [CHANNELS];
    logic             r_mode    [CHANNELS];
    logic [CHANNELS-1:0] r_trigger;

    // Per-channel combinational next values and qualifiers
    state_t              w_state_nxt [CHANNELS];
    logic [WIDTH-1:0]    w_count_nxt [CHANNELS];
    logic [CHANNELS-1:0] w_load;
    logic [CHANNELS-1:0] w_tick;
    logic [CHANNELS-1:0] w_expire;
    logic [CHANNELS-1:0] w_trig_nxt;

    // Load decode and run/expiry qualifiers; out-of-range wr_ch matches no channel
    always_comb begin
        w_load   = '0;
        w_tick   = '0;
        w_expire = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_load[i]   = wr_valid && (32'(wr_ch) == i);
            w_tick[i]   = (r_state[i] == ST_RUN) && enable[i];
            w_expire[i] = w_tick[i] && (r_count[i] == WIDTH'(1));
        end
    end

    // A load on the expiring channel overrides the expiry, so no pulse is emitted
    always_comb begin
        w_trig_nxt = w_expire & ~w_load;
    end

    // FSM state register per channel
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                r_state[i] <= ST_IDLE;
            end else begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    // FSM next-state logic per channel
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_load[i]) begin
                w_state_nxt[i] = (wr_value != '0) ? ST_RUN : ST_IDLE;
            end else begin
                case (r_state[i])
                    ST_IDLE: w_state_nxt[i] = ST_IDLE;
                    ST_RUN: begin
                        if (w_expire[i] && !r_mode[i]) begin
                            w_state_nxt[i] = ST_IDLE;
                        end
                    end
                    default: w_state_nxt[i] = ST_IDLE;
                endcase
            end
        end
    end

    // Count datapath: load, decrement, or expiry (reload or clear); the
    // decrement from 1 is always replaced by expiry so the count never wraps
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_count_nxt[i] = r_count[i];
            if (w_load[i]) begin
                w_count_nxt[i] = wr_value;
            end else if (w_expire[i]) begin
                w_count_nxt[i] = r_mode[i] ? r_reload[i] : '0;
            end else if (w_tick[i]) begin
                w_count_nxt[i] = r_count[i] - WIDTH'(1);
            end
        end
    end

    // Count, reload and mode registers
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                r_count[i]  <= '0;
                r_reload[i] <= '0;
                r_mode[i]   <= 1'b0;
            end else begin
                r_count[i] <= w_count_nxt[i];
                if (w_load[i]) begin
                    r_reload[i] <= wr_value;
                    r_mode[i]   <= wr_mode;
                end
            end
        end
    end

    // Registered expiry pulse; reset suppresses any pending pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trigger <= '0;
        end else begin
            r_trigger <= w_trig_nxt;
        end
    end

    // FSM outputs: busy from state, count packed per channel, trigger from register
    always_comb begin
        busy    = '0;
        count   = '0;
        trigger = r_trigger;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            busy[i]                  = (r_state[i] == ST_RUN);
            count[i*WIDTH +: WIDTH]  = r_count[i];
        end
    end

`ifdef MULTI_TIMER_IRQ_EN
    logic [CHANNELS-1:0] r_irq_pending;

    // Sticky pending flags: set on the same edge trigger rises, cleared by ack; set wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_pending <= '0;
        end else begin
            r_irq_pending <= (r_irq_pending & ~irq_ack) | w_trig_nxt;
        end
    end

    // Interrupt outputs
    always_comb begin
        irq_pending = r_irq_pending;
        irq         = |r_irq_pending;
    end
`endif

endmodule
